// File: rtl/mux_4_to_1_rr_pkg.sv
// rtl/mux_4_to_1_rr_pkg.sv - shared constants and pointer helper for mux_4_to_1_rr
//
// Package mux_pkg: channel count, select width and the round-robin
// pointer wrap function. No ports.
package mux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    // SEL_W bits exactly cover NUM_CH channels, so the natural 2-bit
    // overflow of k + 1 implements (k + 1) mod NUM_CH.
    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] k);
        return k + SEL_W'(1);
    endfunction

endpackage

// File: rtl/mux_4_to_1_rr_if.sv
// rtl/mux_4_to_1_rr_if.sv - channel inputs and output stream bundle for mux_4_to_1_rr
//
// Signals:
//   i_Data0..3 / i_DV0..3 : four producer channels, one-cycle valid pulse
//   o_Data / o_Sel / o_DV : forwarded word, source channel index, valid
//   i_Ready               : downstream accept
//   o_Overflow            : sticky per-channel overflow flags
// Modports:
//   master : producer/consumer side (drives channel inputs and i_Ready)
//   slave  : the multiplexer itself
interface mux_4_to_1_rr_if #(
    parameter int WIDTH = 8
);
    import mux_pkg::*;

    logic [WIDTH-1:0]  i_Data0;
    logic [WIDTH-1:0]  i_Data1;
    logic [WIDTH-1:0]  i_Data2;
    logic [WIDTH-1:0]  i_Data3;
    logic              i_DV0;
    logic              i_DV1;
    logic              i_DV2;
    logic              i_DV3;
    logic [WIDTH-1:0]  o_Data;
    logic [SEL_W-1:0]  o_Sel;
    logic              o_DV;
    logic              i_Ready;
    logic [NUM_CH-1:0] o_Overflow;

    modport master (
        output i_Data0, i_Data1, i_Data2, i_Data3,
        output i_DV0, i_DV1, i_DV2, i_DV3,
        output i_Ready,
        input  o_Data, o_Sel, o_DV, o_Overflow
    );

    modport slave (
        input  i_Data0, i_Data1, i_Data2, i_Data3,
        input  i_DV0, i_DV1, i_DV2, i_DV3,
        input  i_Ready,
        output o_Data, o_Sel, o_DV, o_Overflow
    );

endinterface

// File: rtl/mux_4_to_1_rr_rr_arbiter_4.sv
// rtl/mux_4_to_1_rr_rr_arbiter_4.sv - combinational 4-way arbiter for mux_4_to_1_rr
//
// Ports:
//   req       : in  4-bit request vector (pending flags)
//   ptr       : in  2-bit round-robin start pointer
//   grant_oh  : out one-hot grant
//   grant_idx : out binary grant index
//   any_grant : out at least one request granted
// Macro MUX_FIXED_PRIORITY_EN: when defined, channel 0 always has highest
// priority and ptr is ignored; otherwise the search starts at ptr and wraps.
module rr_arbiter_4
    import mux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant_oh,
    output logic [SEL_W-1:0]  grant_idx,
    output logic              any_grant
);

    logic [SEL_W-1:0] cand;

`ifdef MUX_FIXED_PRIORITY_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;
`endif

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
`ifdef MUX_FIXED_PRIORITY_EN
            cand = SEL_W'(i);
`else
            // 2-bit add wraps, giving ptr, ptr+1, ... mod 4
            cand = ptr + SEL_W'(i);
`endif
            if (!any_grant && req[cand]) begin
                any_grant      = 1'b1;
                grant_idx      = cand;
                grant_oh[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_4_to_1_rr.sv
// rtl/mux_4_to_1_rr.sv - registered 4-to-1 mux with per-channel buffers and round-robin arbitration
//
// Ports:
//   i_Clk   : system clock, rising edge
//   i_Rst_L : asynchronous active-low reset
//   bus     : mux_4_to_1_rr_if.slave (channel inputs, output stream, overflow)
// Each channel owns a one-deep buffer with a pending flag. The output
// register loads the granted buffer whenever it is free (empty or being
// accepted). Words arriving at an occupied, non-draining buffer are dropped
// and flagged in o_Overflow (sticky until reset).
// Macro MUX_FIXED_PRIORITY_EN selects fixed priority (ch0 highest) and
// removes the round-robin pointer register.
module mux_4_to_1_rr
    import mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    mux_4_to_1_rr_if.slave    bus
);

    logic [NUM_CH-1:0] dv_in;
    logic [WIDTH-1:0]  data_in  [NUM_CH];
    logic [WIDTH-1:0]  data_buf [NUM_CH];
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] overflow;
    logic [WIDTH-1:0]  out_data;
    logic [SEL_W-1:0]  out_sel;
    logic              out_dv;
    logic [SEL_W-1:0]  ptr;

    logic [NUM_CH-1:0] grant_oh;
    logic [SEL_W-1:0]  grant_idx;
    logic              any_grant;
    logic              out_free;
    logic              take;
    logic [NUM_CH-1:0] drain;

    assign dv_in      = {bus.i_DV3, bus.i_DV2, bus.i_DV1, bus.i_DV0};
    assign data_in[0] = bus.i_Data0;
    assign data_in[1] = bus.i_Data1;
    assign data_in[2] = bus.i_Data2;
    assign data_in[3] = bus.i_Data3;

    // Output register may change only when empty or being accepted
    assign out_free = !out_dv || bus.i_Ready;
    assign take     = out_free && any_grant;
    assign drain    = grant_oh & {NUM_CH{take}};

    rr_arbiter_4 u_arb (
        .req       (pending),
        .ptr       (ptr),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            pending  <= '0;
            overflow <= '0;
            out_data <= '0;
            out_sel  <= '0;
            out_dv   <= 1'b0;
            for (int n = 0; n < NUM_CH; n++) begin
                data_buf[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (dv_in[n]) begin
                    // A buffer being drained this edge frees up in time
                    // for the new word, so capture+drain loses nothing.
                    if (!pending[n] || drain[n]) begin
                        data_buf[n] <= data_in[n];
                        pending[n]  <= 1'b1;
                    end else begin
                        overflow[n] <= 1'b1;
                    end
                end else if (drain[n]) begin
                    pending[n] <= 1'b0;
                end
            end

            if (out_free) begin
                if (any_grant) begin
                    out_data <= data_buf[grant_idx];
                    out_sel  <= grant_idx;
                    out_dv   <= 1'b1;
                end else begin
                    out_dv   <= 1'b0;
                end
            end
        end
    end

`ifdef MUX_FIXED_PRIORITY_EN
    assign ptr = '0;
`else
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            ptr <= '0;
        end else if (take) begin
            ptr <= next_ptr(grant_idx);
        end
    end
`endif

    assign bus.o_Data     = out_data;
    assign bus.o_Sel      = out_sel;
    assign bus.o_DV       = out_dv;
    assign bus.o_Overflow = overflow;

endmodule

// File: tb/tb_mux_4_to_1_rr.sv
// tb/tb_mux_4_to_1_rr.sv - self-checking bench for mux_4_to_1_rr
module tb_mux_4_to_1_rr;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]   dv;
    logic [W-1:0] din [4];
    logic         rdy;

    mux_4_to_1_rr_if #(.WIDTH(W)) bus ();

    assign bus.i_DV0   = dv[0];
    assign bus.i_DV1   = dv[1];
    assign bus.i_DV2   = dv[2];
    assign bus.i_DV3   = dv[3];
    assign bus.i_Data0 = din[0];
    assign bus.i_Data1 = din[1];
    assign bus.i_Data2 = din[2];
    assign bus.i_Data3 = din[3];
    assign bus.i_Ready = rdy;

    mux_4_to_1_rr #(.WIDTH(W)) dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each channel is a one-slot mailbox, the output is a
    // single held word, and the arbiter picks the first full mailbox in
    // rotating (or fixed) order.
    int m_pend [4];
    int m_buf  [4];
    int m_ovf  [4];
    int m_odv, m_odata, m_osel, m_ptr;

    function automatic void model_reset();
        for (int n = 0; n < 4; n++) begin
            m_pend[n] = 0; m_buf[n] = 0; m_ovf[n] = 0;
        end
        m_odv = 0; m_odata = 0; m_osel = 0; m_ptr = 0;
    endfunction

    function automatic int model_pick();
        int ch;
        for (int i = 0; i < 4; i++) begin
`ifdef MUX_FIXED_PRIORITY_EN
            ch = i;
`else
            ch = (m_ptr + i) % 4;
`endif
            if (m_pend[ch] != 0) return ch;
        end
        return -1;
    endfunction

    function automatic int exp_ovf();
        int v = 0;
        for (int n = 0; n < 4; n++) if (m_ovf[n] != 0) v += (1 << n);
        return v;
    endfunction

    task automatic compare_all();
        check_eq("o_DV", 32'(bus.o_DV), 32'(m_odv));
        check_eq("o_Data", 32'(bus.o_Data), 32'(m_odata));
        check_eq("o_Sel", 32'(bus.o_Sel), 32'(m_osel));
        check_eq("o_Overflow", 32'(bus.o_Overflow), 32'(exp_ovf()));
    endtask

    // Advance one clock: the model consumes the inputs as seen before the edge.
    task automatic step();
        int k;
        bit free;
        int word;
        free = (m_odv == 0) || (rdy == 1'b1);
        k    = free ? model_pick() : -1;
        word = (k >= 0) ? m_buf[k] : 0;
        for (int n = 0; n < 4; n++) begin
            if (dv[n]) begin
                if (m_pend[n] == 0 || n == k) begin
                    m_buf[n]  = int'(din[n]);
                    m_pend[n] = 1;
                end else begin
                    m_ovf[n] = 1;
                end
            end else if (n == k) begin
                m_pend[n] = 0;
            end
        end
        if (free) begin
            if (k >= 0) begin
                m_odata = word;
                m_osel  = k;
                m_odv   = 1;
                m_ptr   = (k + 1) % 4;
            end else begin
                m_odv = 0;
            end
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        dv = 4'b0000;
        for (int n = 0; n < 4; n++) din[n] = '0;
    endtask

    // Short asynchronous reset pulse between clock edges.
    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst o_DV", 32'(bus.o_DV), 32'd0);
        check_eq("rst o_Data", 32'(bus.o_Data), 32'd0);
        check_eq("rst o_Sel", 32'(bus.o_Sel), 32'd0);
        check_eq("rst o_Overflow", 32'(bus.o_Overflow), 32'd0);
        model_reset();
        idle_inputs();
        #3 rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        idle_inputs();
        rdy = 1'b1;

        // Reset held with random inputs
        for (int c = 0; c < 4; c++) begin
            dv  = 4'($urandom);
            for (int n = 0; n < 4; n++) din[n] = W'($urandom);
            rdy = 1'($urandom);
            @(posedge clk);
            #1;
            check_eq("hold o_DV", 32'(bus.o_DV), 32'd0);
            check_eq("hold o_Data", 32'(bus.o_Data), 32'd0);
            check_eq("hold o_Sel", 32'(bus.o_Sel), 32'd0);
            check_eq("hold o_Overflow", 32'(bus.o_Overflow), 32'd0);
        end
        idle_inputs();
        rdy = 1'b1;
        #3 rst_n = 1'b1;
        step();

        // First word: 2-cycle latency
        dv[2] = 1'b1; din[2] = 8'hA5;
        step();
        check_eq("lat t o_DV", 32'(bus.o_DV), 32'd0);
        idle_inputs();
        step();
        check_eq("lat o_DV", 32'(bus.o_DV), 32'd1);
        check_eq("lat o_Data", 32'(bus.o_Data), 32'hA5);
        check_eq("lat o_Sel", 32'(bus.o_Sel), 32'd2);
        step();

        // Simultaneous requests from pointer 0
        do_reset();
        dv = 4'b1111;
        for (int n = 0; n < 4; n++) din[n] = W'(8'h10 + n);
        step();
        idle_inputs();
        for (int n = 0; n < 4; n++) begin
            step();
            check_eq("simul o_Sel", 32'(bus.o_Sel), 32'(n));
            check_eq("simul o_Data", 32'(bus.o_Data), 32'(8'h10 + n));
        end
        step();
        check_eq("simul end o_DV", 32'(bus.o_DV), 32'd0);

        // Fairness after a grant to channel 1
        dv[1] = 1'b1; din[1] = 8'h51;
        step();
        idle_inputs();
        step();
        check_eq("fair pre o_Sel", 32'(bus.o_Sel), 32'd1);
        step();
        dv[0] = 1'b1; din[0] = 8'h60;
        dv[3] = 1'b1; din[3] = 8'h63;
        step();
        idle_inputs();
        step();
`ifdef MUX_FIXED_PRIORITY_EN
        check_eq("fair first", 32'(bus.o_Sel), 32'd0);
        step();
        check_eq("fair second", 32'(bus.o_Sel), 32'd3);
`else
        check_eq("fair first", 32'(bus.o_Sel), 32'd3);
        step();
        check_eq("fair second", 32'(bus.o_Sel), 32'd0);
`endif
        step();

        // Backpressure
        rdy = 1'b0;
        dv[1] = 1'b1; din[1] = 8'h11;
        step();
        idle_inputs();
        dv[2] = 1'b1; din[2] = 8'h44;
        step();
        idle_inputs();
        for (int c = 0; c < 5; c++) begin
            step();
            check_eq("bp o_Data", 32'(bus.o_Data), 32'h11);
            check_eq("bp o_Sel", 32'(bus.o_Sel), 32'd1);
        end
        rdy = 1'b1;
        step();
        check_eq("bp next o_Data", 32'(bus.o_Data), 32'h44);
        check_eq("bp next o_Sel", 32'(bus.o_Sel), 32'd2);
        step();

        // Overflow on channel 1
        rdy = 1'b0;
        dv[0] = 1'b1; din[0] = 8'h01;
        step();
        idle_inputs();
        step();
        dv[1] = 1'b1; din[1] = 8'h22;
        step();
        din[1] = 8'h33;
        step();
        idle_inputs();
        check_eq("ovf flags", 32'(bus.o_Overflow), 32'b0010);
        rdy = 1'b1;
        step();
        check_eq("ovf kept o_Data", 32'(bus.o_Data), 32'h22);
        check_eq("ovf kept o_Sel", 32'(bus.o_Sel), 32'd1);
        step();
        check_eq("ovf no 0x33", 32'(bus.o_DV), 32'd0);
        check_eq("ovf sticky", 32'(bus.o_Overflow), 32'b0010);

        // Reset in the middle of traffic
        rdy = 1'b0;
        dv = 4'b1111;
        for (int n = 0; n < 4; n++) din[n] = W'($urandom);
        step();
        idle_inputs();
        step();
        check_eq("mid o_DV", 32'(bus.o_DV), 32'd1);
        do_reset();
        rdy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq("post rst o_DV", 32'(bus.o_DV), 32'd0);
        end

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            for (int n = 0; n < 4; n++) begin
                dv[n]  = ($urandom_range(0, 2) == 0);
                din[n] = W'($urandom);
            end
            rdy = ($urandom_range(0, 3) != 0);
            if (c == 700) do_reset();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_4_to_1_rr.md
Name: mux_4_to_1_rr

Overview:
- Registered 4-to-1 multiplexer with round-robin arbitration, carrying data in the opposite direction to the team's 1-to-4 demux.
- Four independent producers each present a word with a one-cycle valid pulse; each word is held in a per-channel one-deep buffer.
- Buffered words are forwarded one at a time onto a single valid/ready output stream. Each output word is tagged with its source channel index, so a downstream demux can redistribute it.

Parameters:
- WIDTH, 8, data width in bits of every channel and of the output.

Ports:
- i_Clk  input  1  system clock; all state changes on the rising edge.
- i_Rst_L  input  1  reset, asynchronous and active-low.
- i_Data0..i_Data3  input  WIDTH each  channel data, sampled when the matching i_DVn = 1.
- i_DV0..i_DV3  input  1 each  channel data-valid pulse.
- o_Data  output  WIDTH  forwarded word.
- o_Sel  output  2  source channel index of o_Data (0..3).
- o_DV  output  1  output word valid.
- i_Ready  input  1  downstream accepts o_Data when o_DV & i_Ready.
- o_Overflow  output  4  sticky per-channel overflow flags.

Behaviour:
- Reset (i_Rst_L = 0, asynchronous) sets the following immediately, regardless of the clock:
  - pending flags = 0, buffers = 0, o_DV = 0, o_Data = 0, o_Sel = 0, o_Overflow = 0.
  - Round-robin pointer = 0.
  - Reset mid-transfer discards all buffered and output words. There is no partial output.
- Capture, per channel n, on the rising edge with i_DVn = 1:
  - If buffer n is empty, or is being drained to the output this same edge: load i_Datan and set pending n = 1.
  - Otherwise drop the new word, keep the old word, and set o_Overflow[n] = 1.
  - o_Overflow bits clear only on reset.
- Output register:
  - It is "free" when o_DV = 0, or when o_DV = 1 and i_Ready = 1.
  - When free and at least one pending flag is set, the granted channel k is loaded: o_Data = buffer k, o_Sel = k, o_DV = 1, pending k cleared.
  - When free and nothing is pending, o_DV = 0 next cycle.
  - When not free, o_Data, o_Sel and o_DV hold stable. No change is permitted while o_DV & !i_Ready.
- Arbitration:
  - Search order starts at the pointer and wraps: pointer, pointer+1, ... mod 4. The first pending channel wins.
  - After a grant to channel k, pointer = (k+1) mod 4.
  - The pointer is unchanged when there is no grant.
- Latency:
  - i_DVn at edge t puts the word in the buffer after t. o_DV = 1 after edge t+1 at the earliest, i.e. 2 cycles minimum.
  - There is no bypass path from i_Datan to o_Data.
- Throughput: one word per cycle while i_Ready = 1 and requests are pending.
- Simultaneous events:
  - All four i_DVn may pulse on the same edge. All four are captured, then drained in round-robin order.
  - Capture into a channel and a drain of that same channel on one edge is legal and loses no data.
- Width rule: o_Sel is the 2-bit binary channel index. No data arithmetic is performed.

Optional Feature:
- Macro: MUX_FIXED_PRIORITY_EN.
- Defined: arbitration is fixed priority with channel 0 highest and 3 lowest. The pointer register is not built.
- Undefined (default): round-robin as above.
- Port list is identical in both builds.

Decomposition:
- Package mux_pkg holds:
  - NUM_CH = 4 and SEL_W = 2.
  - A function for next-pointer wrap (k+1 mod NUM_CH).
- Sub-module rr_arbiter_4: combinational. Inputs are a 4-bit request vector and the 2-bit pointer. Outputs are a 4-bit one-hot grant, a 2-bit grant index and any_grant. The MUX_FIXED_PRIORITY_EN selection lives inside it.
- The top level holds buffers, pending flags, overflow flags, output register and pointer.

Test Plan:
- Reset: hold i_Rst_L = 0 with random inputs -> o_DV = 0, o_Data = 0, o_Sel = 0, o_Overflow = 4'b0000. Release, pulse i_DV2 with i_Data2 = 8'hA5, i_Ready = 1 -> o_DV = 1, o_Data = 8'hA5, o_Sel = 2 exactly 2 cycles after the pulse.
- Simultaneous requests: one edge with i_DV0..3 = 1 and data 8'h10, 8'h11, 8'h12, 8'h13, pointer 0, i_Ready = 1 -> four consecutive output words with o_Sel = 0, 1, 2, 3 and matching data, then o_DV = 0. Under MUX_FIXED_PRIORITY_EN the order is also 0, 1, 2, 3.
- Fairness: after a grant to channel 1, pulse i_DV0 and i_DV3 together -> channel 3 is output first (round-robin build), channel 0 first (fixed-priority build).
- Backpressure: i_Ready = 0 with o_DV = 1 and o_Data = 8'h11 for 5 cycles -> o_Data and o_Sel stable. Raise i_Ready -> the next pending word follows the next cycle.
- Overflow: i_Ready = 0 with the output full; pulse i_DV1 with 8'h22, then again with 8'h33 -> o_Overflow = 4'b0010. 8'h22 is delivered later and 8'h33 never appears.
- Reset mid-operation: with 3 channels pending and o_DV = 1, pulse i_Rst_L low for less than one cycle -> all outputs drop to reset values immediately, and no stale word appears after release.
